// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode constants and
// the parity helper. The matching receiver imports this same package.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Callers zero-extend narrower words to 9 bits. Extra zeros do not change the XOR.
    function automatic logic calc_parity(input logic [8:0] data, input int mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side valid/ready word interface of the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit timer: counts 0..CLK_DIV-1 and flags the last cycle of every serial bit.
// A restart forces the count back to zero so a new frame starts on a full bit.
module uart_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Free-running bit counter, zeroed on reset, restart or end of bit
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_done = (count == LAST);
endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: takes a word over valid/ready and sends
// start bit, data bits, optional parity and one or two stop bits on tx.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_cfg_if.slave  host,
    output logic          tx,
    output logic          busy
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_cfg: CLK_DIV must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (LSB_FIRST != 0 && LSB_FIRST != 1) begin : g_bad_lsb_first
        $error("uart_tx_cfg: LSB_FIRST must be 0 or 1");
    end

    uart_state_t          state, state_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic                 stop_cnt, stop_cnt_next;
    logic                 par, par_next;
    logic                 tx_next, ready_next, busy_next;
    logic                 handshake;
    logic                 bit_done;

    assign handshake = (state == ST_IDLE) && host.tx_valid && host.tx_ready;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .restart  (handshake),
        .bit_done (bit_done)
    );

    // State register; tx/ready/busy are registered copies of the next-cycle values
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            shift         <= '0;
            bit_idx       <= '0;
            stop_cnt      <= 1'b0;
            par           <= 1'b0;
            tx            <= 1'b1;
            host.tx_ready <= 1'b1;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            shift         <= shift_next;
            bit_idx       <= bit_idx_next;
            stop_cnt      <= stop_cnt_next;
            par           <= par_next;
            tx            <= tx_next;
            host.tx_ready <= ready_next;
            busy          <= busy_next;
        end
    end

    // Next-state logic: advance one serial bit per bit_done, latch word and parity on handshake
    always_comb begin
        state_next    = state;
        shift_next    = shift;
        bit_idx_next  = bit_idx;
        stop_cnt_next = stop_cnt;
        par_next      = par;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_next    = ST_START;
                    shift_next    = host.tx_data;
                    par_next      = calc_parity(9'(host.tx_data), PARITY);
                    bit_idx_next  = '0;
                    stop_cnt_next = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_IDX) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                        shift_next   = (LSB_FIRST != 0) ? {1'b0, shift[DATA_BITS-1:1]}
                                                        : {shift[DATA_BITS-2:0], 1'b0};
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_next    = ST_IDLE;
                        stop_cnt_next = 1'b0;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered tx changes on the same edge as the state
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = (LSB_FIRST != 0) ? shift_next[0] : shift_next[DATA_BITS-1];
            ST_PARITY: tx_next = par_next;
            default:   tx_next = 1'b1;
        endcase
        ready_next = (state_next == ST_IDLE);
        busy_next  = (state_next != ST_IDLE);
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: four configurations side by side, each checked
// every cycle against a frame-level reference model, plus directed frames.
module tb_uart_tx_cfg;
    localparam int NCFG = 4;
    localparam int CD  [NCFG] = '{4, 4, 4, 4};
    localparam int DB  [NCFG] = '{8, 8, 8, 7};
    localparam int PAR [NCFG] = '{0, 1, 2, 2};
    localparam int SB  [NCFG] = '{1, 1, 1, 2};
    localparam int LSB [NCFG] = '{1, 1, 1, 0};

    // Hand-derived frames in send order (bit 0 is sent first)
    localparam logic [15:0] EXP_SEQ [NCFG] = '{16'h034A, 16'h054A, 16'h074A, 16'h06FE};
    localparam int          EXP_LEN [NCFG] = '{10, 11, 11, 11};
    localparam int          EXP_F   [NCFG] = '{40, 44, 44, 44};
    localparam logic [8:0]  PIN_WORD[NCFG] = '{9'h0A5, 9'h0A5, 9'h0A5, 9'h07F};

    logic clk = 1'b0;
    logic rst;
    logic       valid [NCFG];
    logic [8:0] data  [NCFG];
    wire        tx_o    [NCFG];
    wire        ready_o [NCFG];
    wire        busy_o  [NCFG];

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_BITS(8)) bus_a ();
    uart_tx_cfg_if #(.DATA_BITS(8)) bus_b ();
    uart_tx_cfg_if #(.DATA_BITS(8)) bus_c ();
    uart_tx_cfg_if #(.DATA_BITS(7)) bus_d ();

    assign bus_a.tx_valid = valid[0];
    assign bus_a.tx_data  = data[0][7:0];
    assign ready_o[0]     = bus_a.tx_ready;
    assign bus_b.tx_valid = valid[1];
    assign bus_b.tx_data  = data[1][7:0];
    assign ready_o[1]     = bus_b.tx_ready;
    assign bus_c.tx_valid = valid[2];
    assign bus_c.tx_data  = data[2][7:0];
    assign ready_o[2]     = bus_c.tx_ready;
    assign bus_d.tx_valid = valid[3];
    assign bus_d.tx_data  = data[3][6:0];
    assign ready_o[3]     = bus_d.tx_ready;

    uart_tx_cfg #(.CLK_DIV(CD[0]), .DATA_BITS(DB[0]), .PARITY(PAR[0]), .STOP_BITS(SB[0]), .LSB_FIRST(LSB[0]))
        dut_a (.clk(clk), .rst(rst), .host(bus_a), .tx(tx_o[0]), .busy(busy_o[0]));
    uart_tx_cfg #(.CLK_DIV(CD[1]), .DATA_BITS(DB[1]), .PARITY(PAR[1]), .STOP_BITS(SB[1]), .LSB_FIRST(LSB[1]))
        dut_b (.clk(clk), .rst(rst), .host(bus_b), .tx(tx_o[1]), .busy(busy_o[1]));
    uart_tx_cfg #(.CLK_DIV(CD[2]), .DATA_BITS(DB[2]), .PARITY(PAR[2]), .STOP_BITS(SB[2]), .LSB_FIRST(LSB[2]))
        dut_c (.clk(clk), .rst(rst), .host(bus_c), .tx(tx_o[2]), .busy(busy_o[2]));
    uart_tx_cfg #(.CLK_DIV(CD[3]), .DATA_BITS(DB[3]), .PARITY(PAR[3]), .STOP_BITS(SB[3]), .LSB_FIRST(LSB[3]))
        dut_d (.clk(clk), .rst(rst), .host(bus_d), .tx(tx_o[3]), .busy(busy_o[3]));

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Reference frame: list of line levels in send order, one entry per serial bit
    function automatic void build_frame(input int g, input logic [8:0] d,
                                        output logic [15:0] bits, output int len);
        int   n;
        logic p;
        n    = 0;
        p    = 1'b0;
        bits = '1;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < DB[g]; i++) begin
            bits[n] = d[(LSB[g] != 0) ? i : DB[g] - 1 - i];
            n++;
        end
        if (PAR[g] != 0) begin
            for (int i = 0; i < DB[g]; i++) p = p ^ d[i];
            bits[n] = (PAR[g] == 2) ? ~p : p;
            n++;
        end
        for (int i = 0; i < SB[g]; i++) begin
            bits[n] = 1'b1;
            n++;
        end
        len = n;
    endfunction

    // Model state: whether a frame is on the line, cycles since its handshake, its bits
    bit          m_busy [NCFG];
    int          m_cyc  [NCFG];
    logic [15:0] m_bits [NCFG];
    int          m_len  [NCFG];
    bit          model_live = 1'b0;

    always @(posedge clk) begin
        for (int g = 0; g < NCFG; g++) begin
            if (rst) begin
                m_busy[g] = 1'b0;
                m_cyc[g]  = 0;
            end else if (!m_busy[g]) begin
                if (valid[g]) begin
                    build_frame(g, data[g], m_bits[g], m_len[g]);
                    m_busy[g] = 1'b1;
                    m_cyc[g]  = 0;
                end
            end else begin
                m_cyc[g]++;
                if (m_cyc[g] == m_len[g] * CD[g]) m_busy[g] = 1'b0;
            end
        end
        if (rst) model_live = 1'b1;
    end

    // Every cycle: compare {tx, tx_ready, busy} of each configuration with the model
    always @(negedge clk) begin
        if (model_live) begin
            for (int g = 0; g < NCFG; g++) begin
                logic e_tx;
                e_tx = m_busy[g] ? m_bits[g][m_cyc[g] / CD[g]] : 1'b1;
                check_output($sformatf("cycle_cfg%0d", g),
                             32'({tx_o[g], ready_o[g], busy_o[g]}),
                             32'({e_tx, ~m_busy[g], m_busy[g]}));
            end
        end
    end

    task automatic wait_idle(input int g);
        int guard;
        guard = 0;
        while (ready_o[g] !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_output($sformatf("idle_before_frame_cfg%0d", g), 32'(ready_o[g]), 32'd1);
    endtask

    // One handshake, then a 120-cycle trace of tx while tx_data keeps changing
    task automatic run_frame(input int g, input logic [8:0] d,
                             output logic [119:0] tr, output int rdy_at);
        wait_idle(g);
        valid[g] = 1'b1;
        data[g]  = d;
        @(posedge clk);
        @(negedge clk);
        valid[g] = 1'b0;
        tr       = '1;
        rdy_at   = -1;
        for (int k = 0; k < 120; k++) begin
            tr[k] = tx_o[g];
            if (rdy_at < 0 && ready_o[g] === 1'b1) rdy_at = k;
            data[g] = 9'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input int g, input string tag, input logic [8:0] d);
        logic [119:0] tr;
        logic [15:0]  seq;
        int           rdy_at;
        run_frame(g, d, tr, rdy_at);
        seq = '0;
        for (int i = 0; i < EXP_LEN[g]; i++) seq[i] = tr[i * CD[g] + CD[g] / 2];
        check_output($sformatf("%s_seq_cfg%0d", tag, g), 32'(seq), 32'(EXP_SEQ[g]));
        check_output($sformatf("%s_ready_return_cfg%0d", tag, g), rdy_at, EXP_F[g]);
    endtask

    function automatic logic [8:0] decode_word(input int g, input logic [159:0] tr, input int base);
        logic [8:0] w;
        w = '0;
        for (int i = 0; i < DB[g]; i++)
            w[(LSB[g] != 0) ? i : DB[g] - 1 - i] = tr[base + (1 + i) * CD[g] + CD[g] / 2];
        return w;
    endfunction

    // tx_valid held high across two words; tx_data changes while frames are in flight
    task automatic gap_test(input int g, input logic [8:0] d1, input logic [8:0] d2);
        logic [159:0] tr;
        logic [8:0]   mask;
        bit           seen_hi;
        int           s, run, dend, k, f;
        mask = 9'((1 << DB[g]) - 1);
        f    = (1 + DB[g] + ((PAR[g] != 0) ? 1 : 0) + SB[g]) * CD[g];
        wait_idle(g);
        valid[g] = 1'b1;
        data[g]  = d1;
        @(posedge clk);
        @(negedge clk);
        data[g] = d2;
        seen_hi = 1'b0;
        for (int c = 0; c < 160; c++) begin
            tr[c] = tx_o[g];
            if (ready_o[g] === 1'b1) seen_hi = 1'b1;
            else if (seen_hi) valid[g] = 1'b0;
            if (!valid[g]) data[g] = 9'($urandom);
            @(negedge clk);
        end
        valid[g] = 1'b0;
        dend = (1 + DB[g] + ((PAR[g] != 0) ? 1 : 0)) * CD[g];
        s = -1;
        for (int c = dend; c < 160; c++) if (s < 0 && tr[c] == 1'b0) s = c;
        run = 0;
        k   = s - 1;
        while (k >= 0 && tr[k] == 1'b1) begin
            run++;
            k--;
        end
        check_output($sformatf("second_start_cfg%0d", g), s, f + 1);
        check_output($sformatf("gap_high_cfg%0d", g), run, SB[g] * CD[g] + 1);
        check_output($sformatf("first_word_cfg%0d", g), 32'(decode_word(g, tr, 0)), 32'(d1 & mask));
        if (s >= 0 && s + f <= 160)
            check_output($sformatf("second_word_cfg%0d", g), 32'(decode_word(g, tr, s)), 32'(d2 & mask));
        else
            check_output($sformatf("second_word_cfg%0d", g), 32'h1FF, 32'(d2 & mask));
    endtask

    task automatic apply_stimulus();
        rst = ($urandom_range(0, 399) == 0);
        for (int g = 0; g < NCFG; g++) begin
            valid[g] = ($urandom_range(0, 2) == 0);
            data[g]  = 9'($urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] pb;
        int          pl;
        rst = 1'b1;
        for (int g = 0; g < NCFG; g++) begin
            valid[g] = 1'b1;
            data[g]  = 9'h155;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NCFG; g++) begin
            check_output($sformatf("reset_state_cfg%0d", g),
                         32'({tx_o[g], ready_o[g], busy_o[g]}), 32'b110);
            valid[g] = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] model pins");
        for (int g = 0; g < NCFG; g++) begin
            build_frame(g, PIN_WORD[g], pb, pl);
            check_output($sformatf("model_len_cfg%0d", g), pl, EXP_LEN[g]);
            check_output($sformatf("model_seq_cfg%0d", g),
                         32'(pb & 16'((32'd1 << pl) - 1)), 32'(EXP_SEQ[g]));
        end

        $display("[TB] directed frames");
        for (int g = 0; g < NCFG; g++) check_frame(g, "pin", PIN_WORD[g]);

        $display("[TB] back-to-back frames");
        gap_test(0, 9'h001, 9'h080);
        gap_test(3, 9'h001, 9'h040);

        $display("[TB] reset during third data bit");
        wait_idle(0);
        valid[0] = 1'b1;
        data[0]  = 9'h05A;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("reset_mid_frame", 32'({tx_o[0], ready_o[0], busy_o[0]}), 32'b110);
        rst = 1'b0;
        check_frame(0, "after_reset", 9'h0A5);

        $display("[TB] tx_valid pulsed while busy");
        wait_idle(1);
        valid[1] = 1'b1;
        data[1]  = 9'h03C;
        @(posedge clk);
        @(negedge clk);
        valid[1] = 1'b0;
        repeat (10) @(negedge clk);
        check_output("busy_during_frame", 32'(busy_o[1]), 32'd1);
        valid[1] = 1'b1;
        data[1]  = 9'h0FF;
        @(negedge clk);
        valid[1] = 1'b0;
        repeat (43) @(negedge clk);
        check_output("no_extra_frame", 32'({tx_o[1], ready_o[1], busy_o[1]}), 32'b110);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            apply_stimulus();
            @(negedge clk);
        end
        rst = 1'b0;
        for (int g = 0; g < NCFG; g++) valid[g] = 1'b0;
        repeat (60) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
